// File: rtl/trng_rejector.sv
// trng_rejector: fetches 256-bit samples from the trng block as eight 32-bit
// words (most significant word first), keeps only samples below the modulus P
// and presents accepted values on a valid/ready output. A staging register
// lets the next sample be fetched while the output waits on backpressure.
module trng_rejector #(
  parameter logic [255:0] P     = 256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff,
  parameter int unsigned  REJ_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic             o_trng_en,
  input  logic             i_trng_rdy,
  output logic             o_trng_rd_en,
  output logic [2:0]       o_trng_addr,
  input  logic [31:0]      i_trng_out,
  output logic [255:0]     o_rnd_data,
  output logic             o_rnd_valid,
  input  logic             i_rnd_ready,
  output logic [REJ_W-1:0] o_reject_cnt,
  output logic             o_busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_READ    = 3'd4,
    S_CHECK   = 3'd5,
    S_HOLD    = 3'd6
  } state_t;

  state_t             r_state;
  logic               r_trng_en;
  logic               r_rd_en;
  logic [2:0]         r_addr;
  logic [3:0]         r_cnt;       // READ cycle index 0..8
  logic [255:0]       r_stage;     // sample being assembled / waiting for the output slot
  logic               r_lt;        // sample proven smaller than P
  logic               r_decided;   // serial compare already resolved
  logic [255:0]       r_data;
  logic               r_valid;
  logic [REJ_W-1:0]   r_rej;
  logic               r_busy;

  logic [2:0]         w_idx;       // word index of the data arriving this READ cycle
  logic [31:0]        w_p_word;
  logic               w_slot_free;
  logic               w_load;

  // Data on i_trng_out in READ cycle n belongs to the strobe of cycle n-1 (word 8-n).
  assign w_idx       = 3'(4'd8 - r_cnt);
  assign w_p_word    = P[{w_idx, 5'd0} +: 32];
  // The output register can take a new value if empty or being drained right now.
  assign w_slot_free = !r_valid || i_rnd_ready;
  assign w_load      = w_slot_free &&
                       (((r_state == S_CHECK) && r_lt) || (r_state == S_HOLD));

  // Control FSM: request, wait for the trng run, read/compare words, accept or reject.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_trng_en <= 1'b0;
      r_rd_en   <= 1'b0;
      r_addr    <= 3'd0;
      r_cnt     <= 4'd0;
      r_stage   <= 256'd0;
      r_lt      <= 1'b0;
      r_decided <= 1'b0;
      r_rej     <= {REJ_W{1'b0}};
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // trng_rdy=1 also guards against a run left in flight across a reset.
          if (i_en && i_trng_rdy) begin
            r_state   <= S_REQ;
            r_trng_en <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_REQ: begin
          r_trng_en <= 1'b0;
          r_state   <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          if (!i_trng_rdy) begin
            r_state <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (i_trng_rdy) begin
            r_state   <= S_READ;
            r_rd_en   <= 1'b1;
            r_addr    <= 3'd7;
            r_cnt     <= 4'd0;
            r_lt      <= 1'b0;
            r_decided <= 1'b0;
          end
        end
        S_READ: begin
          if (r_cnt != 4'd0) begin
            r_stage[{w_idx, 5'd0} +: 32] <= i_trng_out;
            if (!r_decided) begin
              if (i_trng_out < w_p_word) begin
                r_lt      <= 1'b1;
                r_decided <= 1'b1;
              end else if (i_trng_out > w_p_word) begin
                r_decided <= 1'b1;
              end
            end
          end
          if (r_cnt < 4'd7) begin
            r_addr <= r_addr - 3'd1;
          end else begin
            r_rd_en <= 1'b0;
            r_addr  <= 3'd0;
          end
          if (r_cnt == 4'd8) begin
            r_state <= S_CHECK;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_CHECK: begin
          if (r_lt) begin
            if (w_slot_free) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_HOLD;
            end
          end else begin
            if (r_rej != {REJ_W{1'b1}}) begin
              r_rej <= r_rej + {{(REJ_W-1){1'b0}}, 1'b1};
            end
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_HOLD: begin
          if (w_slot_free) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_trng_en <= 1'b0;
          r_rd_en   <= 1'b0;
          r_addr    <= 3'd0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  // Output slot: load an accepted sample when free, otherwise drop valid after a handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data  <= 256'd0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_data  <= r_stage;
      r_valid <= 1'b1;
    end else if (r_valid && i_rnd_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_trng_en    = r_trng_en;
  assign o_trng_rd_en = r_rd_en;
  assign o_trng_addr  = r_addr;
  assign o_rnd_data   = r_data;
  assign o_rnd_valid  = r_valid;
  assign o_reject_cnt = r_rej;
  assign o_busy       = r_busy;

endmodule
